// File: rtl/sha256_nonce_sched.sv
// sha256_nonce_sched: drives one shared simplified_sha256 core through a nonce
// sweep. Per nonce: phase-2 hash (midstate + tail + nonce), phase-3 hash on that
// digest, then {nonce, H0} is streamed out over valid/ready.
// Optional feature macro: SHA_SCHED_TARGET_CMP_EN (adds target/res_hit and ends
// the job after the first result whose H0 is below target).
module sha256_nonce_sched #(
  parameter int unsigned NUM_NONCES   = 16,
  parameter int unsigned NONCE_W      = 4,
  parameter int unsigned FINISH_BLANK = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0][31:0]     midstate,
  input  logic [2:0][31:0]     msg_tail,
`ifdef SHA_SCHED_TARGET_CMP_EN
  input  logic [31:0]          target,
  output logic                 res_hit,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 core_start,
  output logic                 core_phase_sel,
  output logic [NONCE_W-1:0]   core_nonce,
  output logic [7:0][31:0]     core_hi,
  output logic [2:0][31:0]     core_msg_tail,
  input  logic [7:0][31:0]     core_ho,
  input  logic                 core_finish,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [NONCE_W-1:0]   res_nonce,
  output logic [31:0]          res_h0
);

  localparam int unsigned BLANK_W = $clog2(FINISH_BLANK + 2);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_P2_GO   = 3'd1;
  localparam logic [2:0] S_P2_WAIT = 3'd2;
  localparam logic [2:0] S_P3_GO   = 3'd3;
  localparam logic [2:0] S_P3_WAIT = 3'd4;
  localparam logic [2:0] S_EMIT    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]          state_q, state_d;
  logic [NONCE_W-1:0]  nonce_q, nonce_d;
  logic [BLANK_W-1:0]  blank_q, blank_d;
  logic [7:0][31:0]    mid_q, mid_d;
  logic [2:0][31:0]    tail_d;
  logic                phase_d;
  logic [NONCE_W-1:0]  cnonce_d;
  logic [7:0][31:0]    hi_d;
  logic                res_valid_d;
  logic [NONCE_W-1:0]  res_nonce_d;
  logic [31:0]         res_h0_d;
  logic                job_end;
`ifdef SHA_SCHED_TARGET_CMP_EN
  logic [31:0]         target_q, target_d;
  logic                hit_d;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d     = state_q;
    nonce_d     = nonce_q;
    blank_d     = blank_q;
    mid_d       = mid_q;
    tail_d      = core_msg_tail;
    phase_d     = core_phase_sel;
    cnonce_d    = core_nonce;
    hi_d        = core_hi;
    res_valid_d = res_valid;
    res_nonce_d = res_nonce;
    res_h0_d    = res_h0;
    job_end     = (nonce_q == NONCE_W'(NUM_NONCES - 1));
`ifdef SHA_SCHED_TARGET_CMP_EN
    target_d    = target_q;
    hit_d       = res_hit;
    job_end     = job_end | res_hit;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mid_d    = midstate;
          tail_d   = msg_tail;
          nonce_d  = '0;
          phase_d  = 1'b0;
          cnonce_d = '0;
          hi_d     = midstate;
`ifdef SHA_SCHED_TARGET_CMP_EN
          target_d = target;
`endif
          state_d  = S_P2_GO;
        end
      end
      S_P2_GO: begin
        blank_d = BLANK_W'(FINISH_BLANK);
        state_d = S_P2_WAIT;
      end
      S_P2_WAIT: begin
        if (blank_q != '0) begin
          blank_d = blank_q - BLANK_W'(1);
        end else if (core_finish) begin
          // Phase-2 digest goes straight onto core_hi for the phase-3 run.
          hi_d    = core_ho;
          phase_d = 1'b1;
          state_d = S_P3_GO;
        end
      end
      S_P3_GO: begin
        blank_d = BLANK_W'(FINISH_BLANK);
        state_d = S_P3_WAIT;
      end
      S_P3_WAIT: begin
        if (blank_q != '0) begin
          blank_d = blank_q - BLANK_W'(1);
        end else if (core_finish) begin
          res_valid_d = 1'b1;
          res_nonce_d = nonce_q;
          res_h0_d    = core_ho[0];
`ifdef SHA_SCHED_TARGET_CMP_EN
          hit_d       = (core_ho[0] < target_q);
`endif
          state_d     = S_EMIT;
        end
      end
      S_EMIT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          if (job_end) begin
            state_d = S_DONE;
          end else begin
            nonce_d  = nonce_q + NONCE_W'(1);
            cnonce_d = nonce_q + NONCE_W'(1);
            phase_d  = 1'b0;
            hi_d     = mid_q;
            state_d  = S_P2_GO;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      nonce_q        <= '0;
      blank_q        <= '0;
      mid_q          <= '0;
      core_msg_tail  <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      core_start     <= 1'b0;
      core_phase_sel <= 1'b0;
      core_nonce     <= '0;
      core_hi        <= '0;
      res_valid      <= 1'b0;
      res_nonce      <= '0;
      res_h0         <= '0;
`ifdef SHA_SCHED_TARGET_CMP_EN
      target_q       <= '0;
      res_hit        <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      nonce_q        <= nonce_d;
      blank_q        <= blank_d;
      mid_q          <= mid_d;
      core_msg_tail  <= tail_d;
      busy           <= (state_d != S_IDLE) && (state_d != S_DONE);
      done           <= (state_d == S_DONE);
      core_start     <= (state_d == S_P2_GO) || (state_d == S_P3_GO);
      core_phase_sel <= phase_d;
      core_nonce     <= cnonce_d;
      core_hi        <= hi_d;
      res_valid      <= res_valid_d;
      res_nonce      <= res_nonce_d;
      res_h0         <= res_h0_d;
`ifdef SHA_SCHED_TARGET_CMP_EN
      target_q       <= target_d;
      res_hit        <= hit_d;
`endif
    end
  end

endmodule

// File: tb/tb_sha256_nonce_sched.sv
// Directed testbench for sha256_nonce_sched with a behavioural hash-core model.
module tb_sha256_nonce_sched;

  localparam int unsigned NUM_NONCES   = 16;
  localparam int unsigned NONCE_W      = 4;
  localparam int unsigned FINISH_BLANK = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [7:0][31:0]    midstate;
  logic [2:0][31:0]    msg_tail;
  logic                busy;
  logic                done;
  logic                core_start;
  logic                core_phase_sel;
  logic [NONCE_W-1:0]  core_nonce;
  logic [7:0][31:0]    core_hi;
  logic [2:0][31:0]    core_msg_tail;
  logic [7:0][31:0]    core_ho;
  logic                core_finish;
  logic                res_valid;
  logic                res_ready;
  logic [NONCE_W-1:0]  res_nonce;
  logic [31:0]         res_h0;
`ifdef SHA_SCHED_TARGET_CMP_EN
  logic [31:0]         target;
  logic                res_hit;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit spur_en  = 1'b0;

  logic [7:0][31:0] mid_a, mid_b;
  logic [2:0][31:0] tail_a, tail_b;

  sha256_nonce_sched #(
    .NUM_NONCES  (NUM_NONCES),
    .NONCE_W     (NONCE_W),
    .FINISH_BLANK(FINISH_BLANK)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .midstate      (midstate),
    .msg_tail      (msg_tail),
`ifdef SHA_SCHED_TARGET_CMP_EN
    .target        (target),
    .res_hit       (res_hit),
`endif
    .busy          (busy),
    .done          (done),
    .core_start    (core_start),
    .core_phase_sel(core_phase_sel),
    .core_nonce    (core_nonce),
    .core_hi       (core_hi),
    .core_msg_tail (core_msg_tail),
    .core_ho       (core_ho),
    .core_finish   (core_finish),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_nonce     (res_nonce),
    .res_h0        (res_h0)
  );

  always #5 clk = ~clk;

  // Behavioural core: phase 2 adds the nonce, phase 3 xors a constant.
  function automatic logic [7:0][31:0] core_fn(input logic [7:0][31:0] hi,
                                               input logic ph,
                                               input logic [NONCE_W-1:0] n);
    logic [7:0][31:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = ph ? (hi[i] ^ 32'hFFFF0000) : (hi[i] + 32'(n));
    return r;
  endfunction

  logic [7:0][31:0]   m_hi;
  logic               m_ph;
  logic [NONCE_W-1:0] m_n;
  int                 m_cnt;
  bit                 m_spur;

  // Core model: finish 67 cycles after core_start, optional early spurious pulse.
  always @(posedge clk) begin
    if (reset) begin
      m_cnt       <= 0;
      m_spur      <= 1'b0;
      core_finish <= 1'b0;
      core_ho     <= '0;
    end else begin
      core_finish <= 1'b0;
      if (core_start) begin
        m_cnt  <= 67;
        m_hi   <= core_hi;
        m_ph   <= core_phase_sel;
        m_n    <= core_nonce;
        m_spur <= spur_en;
      end else begin
        if (m_spur) begin
          core_finish <= 1'b1;
          core_ho     <= {8{32'hBAD0_0000}};
          m_spur      <= 1'b0;
        end
        if (m_cnt == 1) begin
          core_finish <= 1'b1;
          core_ho     <= core_fn(m_hi, m_ph, m_n);
        end
        if (m_cnt != 0) m_cnt <= m_cnt - 1;
      end
    end
  end

  // Runs one full job from mid_a/tail_a and checks every emitted result.
  task automatic run_sweep(input string tag, input int bp_nonce, input bit poke);
    int exp_n;
    int hold;
    int n_cs;
    bit fin;
    bit prev_cs;
    logic [31:0] exp_h0;
    exp_n = 0; hold = 0; n_cs = 0; fin = 1'b0; prev_cs = 1'b0;
    midstate = mid_a; msg_tail = tail_a; res_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 20000 && !fin; cyc++) begin
      start = 1'b0;
      if (poke && cyc == 5) begin
        midstate = mid_b; msg_tail = tail_b; start = 1'b1;
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++; $display("FAIL %s busy_at_poke: got %b expected 1", tag, busy);
        end
      end
      if (core_start) begin
        n_cs++;
        n_checks++;
        if (prev_cs) begin
          n_fail++; $display("FAIL %s core_start_width: high two cycles in a row at cycle %0d", tag, cyc);
        end
      end
      prev_cs = core_start;
      res_ready = 1'b1;
      if (res_valid && int'(res_nonce) == bp_nonce && hold < 10) begin
        res_ready = 1'b0;
        hold++;
        exp_h0 = (mid_a[0] + 32'(bp_nonce)) ^ 32'hFFFF0000;
        n_checks++;
        if (res_h0 !== exp_h0 || core_start !== 1'b0) begin
          n_fail++;
          $display("FAIL %s hold: h0 %h core_start %b expected h0 %h core_start 0", tag, res_h0, core_start, exp_h0);
        end
      end
      if (res_valid && res_ready) begin
        exp_h0 = (mid_a[0] + 32'(exp_n)) ^ 32'hFFFF0000;
        n_checks++;
        if (res_nonce !== NONCE_W'(exp_n) || res_h0 !== exp_h0) begin
          n_fail++;
          $display("FAIL %s result: nonce %0d h0 %h expected nonce %0d h0 %h", tag, res_nonce, res_h0, exp_n, exp_h0);
        end
`ifdef SHA_SCHED_TARGET_CMP_EN
        n_checks++;
        if (res_hit !== 1'b0) begin
          n_fail++; $display("FAIL %s res_hit: got %b expected 0", tag, res_hit);
        end
`endif
        exp_n++;
      end
      if (done) begin
        n_checks++;
        if (exp_n != NUM_NONCES || busy !== 1'b0 || core_msg_tail !== tail_a || n_cs != 2 * NUM_NONCES) begin
          n_fail++;
          $display("FAIL %s done: results %0d busy %b tail %h starts %0d expected %0d 0 %h %0d",
                   tag, exp_n, busy, core_msg_tail, n_cs, NUM_NONCES, tail_a, 2 * NUM_NONCES);
        end
        fin = 1'b1;
      end
      @(negedge clk);
    end
    n_checks++;
    if (!fin) begin
      n_fail++; $display("FAIL %s timeout: done never seen, results %0d expected %0d", tag, exp_n, NUM_NONCES);
    end else if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s after_done: done %b busy %b expected 0 0", tag, done, busy);
    end
    if (bp_nonce >= 0) begin
      n_checks++;
      if (hold != 10) begin
        n_fail++; $display("FAIL %s hold_cycles: got %0d expected 10", tag, hold);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; res_ready = 1'b0;
    midstate = mid_a; msg_tail = tail_a;
`ifdef SHA_SCHED_TARGET_CMP_EN
    target = 32'h0;
`endif
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || core_start !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: busy %b done %b core_start %b res_valid %b expected all 0", busy, done, core_start, res_valid);
    end
    n_checks++;
    if (core_phase_sel !== 1'b0 || core_nonce !== '0 || core_hi !== '0) begin
      n_fail++;
      $display("FAIL reset_core: phase %b nonce %0d hi %h expected 0", core_phase_sel, core_nonce, core_hi);
    end
    n_checks++;
    if (res_nonce !== '0 || res_h0 !== 32'h0) begin
      n_fail++; $display("FAIL reset_res: nonce %0d h0 %h expected 0 0", res_nonce, res_h0);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || core_start !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold: busy %b core_start %b expected 0 0", busy, core_start);
    end
  endtask

  task automatic test_basic_sweep();
    run_sweep("basic", -1, 1'b0);
  endtask

  task automatic test_backpressure();
    run_sweep("backpressure", 3, 1'b0);
  endtask

  task automatic test_spurious_finish();
    spur_en = 1'b1;
    run_sweep("spurious", -1, 1'b0);
    spur_en = 1'b0;
  endtask

  task automatic test_start_while_busy();
    run_sweep("start_busy", -1, 1'b1);
  endtask

  task automatic test_reset_mid_job();
    bit seen;
    seen = 1'b0;
    midstate = mid_a; msg_tail = tail_a; res_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 5000 && !seen; cyc++) begin
      if (core_start && core_phase_sel && core_nonce == NONCE_W'(7)) seen = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL mid_reset_reach: nonce 7 phase 3 start not seen, got 0 expected 1");
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || core_phase_sel !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset_pre: busy %b phase %b expected 1 1", busy, core_phase_sel);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || core_start !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: res_valid %b busy %b core_start %b expected 0 0 0", res_valid, busy, core_start);
    end
    n_checks++;
    if (core_nonce !== '0 || res_nonce !== '0) begin
      n_fail++; $display("FAIL mid_reset_nonce: core %0d res %0d expected 0 0", core_nonce, res_nonce);
    end
    reset = 1'b0;
    @(negedge clk);
    run_sweep("restart", -1, 1'b0);
  endtask

`ifdef SHA_SCHED_TARGET_CMP_EN
  task automatic test_target();
    bit got;
    bit saw_done;
    bit saw_cs;
    got = 1'b0; saw_done = 1'b0; saw_cs = 1'b0;
    target = 32'hEFFF0005;
    midstate = mid_a; msg_tail = tail_a; res_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 500 && !got; cyc++) begin
      if (res_valid) got = 1'b1;
      else @(negedge clk);
    end
    n_checks++;
    if (!got || res_hit !== 1'b1 || res_nonce !== '0 || res_h0 !== 32'hEFFF0000) begin
      n_fail++;
      $display("FAIL target_hit: valid %b hit %b nonce %0d h0 %h expected 1 1 0 efff0000", got, res_hit, res_nonce, res_h0);
    end
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
      if (core_start) saw_cs = 1'b1;
    end
    n_checks++;
    if (!saw_done || saw_cs || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL target_end: done %b core_start %b busy %b expected 1 0 0", saw_done, saw_cs, busy);
    end
    target = 32'h0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) begin
      mid_a[i] = 32'h1000_0000 + 32'(i);
      mid_b[i] = 32'h2000_0000 + 32'(i);
    end
    tail_a = {32'hA000_0003, 32'hA000_0002, 32'hA000_0001};
    tail_b = {32'hB000_0003, 32'hB000_0002, 32'hB000_0001};
    test_reset();
    test_basic_sweep();
    test_backpressure();
    test_spurious_finish();
    test_start_while_busy();
    test_reset_mid_job();
`ifdef SHA_SCHED_TARGET_CMP_EN
    test_target();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
